// File: rtl/fifo_reuse_pkg.sv
// Shared state encoding and parameter defaults for the scratchpad FIFO reuse sequencer.
package fifo_reuse_pkg;
  localparam int DEF_FIFO_SIZE = 8;
  localparam int DEF_ADD_WIDTH = 3;
  localparam int DEF_CNT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LOAD   = 3'd2,
    READ   = 3'd3,
    REWIND = 3'd4,
    DONE   = 3'd5
  } state_e;
endpackage

// File: rtl/reuse_counter.sv
// Generic up-counter with synchronous clear, count enable and a terminal-match flag.
module reuse_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] cnt,
  output logic             at_term
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign at_term = (cnt_q == term);
endmodule

// File: rtl/fifo_reuse_ctrl.sv
// Clear / load / replay sequencer for one PE scratchpad FIFO with registered read.
// Optional READ-stall counter output stall_cycles is enabled by defining FIFO_REUSE_PERF_EN.
module fifo_reuse_ctrl
  import fifo_reuse_pkg::*;
#(
  parameter int FIFO_SIZE = DEF_FIFO_SIZE,
  parameter int ADD_WIDTH = DEF_ADD_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADD_WIDTH:0]   cfg_len,
  input  logic [CNT_WIDTH-1:0] cfg_reuse,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic                 wr_en,
  output logic                 wr_inc,
  output logic                 rd_en,
  output logic                 rd_inc,
  output logic                 wr_clr,
  output logic                 rd_clr,
  output logic [CNT_WIDTH-1:0] pass_idx,
  output logic                 busy,
`ifdef FIFO_REUSE_PERF_EN
  output logic [15:0]          stall_cycles,
`endif
  output logic                 done
);
  localparam logic [ADD_WIDTH:0] SIZE_L = (ADD_WIDTH+1)'(FIFO_SIZE);

  state_e               state_q, state_d;
  logic [ADD_WIDTH:0]   len_q, len_d;
  logic [CNT_WIDTH-1:0] reuse_q, reuse_d;
  logic                 wr_clr_q, wr_clr_d;
  logic                 rd_clr_q, rd_clr_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 out_valid_q, out_valid_d;

  logic [ADD_WIDTH:0]   len_clamp;
  logic                 wr_fire, rd_fire;
  logic [ADD_WIDTH:0]   wr_cnt, rd_cnt;
  logic                 wr_at_term, rd_at_term, pass_at_term;
  logic                 unused_cnt_bits;

  assign len_clamp = (cfg_len > SIZE_L) ? SIZE_L : cfg_len;
  assign wr_fire   = (state_q == LOAD) && in_valid;
  assign rd_fire   = (state_q == READ) && out_ready;

  reuse_counter #(.WIDTH(ADD_WIDTH+1)) u_wr_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == CLEAR),
    .en      (wr_fire),
    .term    (len_q - 1'b1),
    .cnt     (wr_cnt),
    .at_term (wr_at_term)
  );

  // The read counter restarts every pass; the pass counter only on a new job.
  reuse_counter #(.WIDTH(ADD_WIDTH+1)) u_rd_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     ((state_q == CLEAR) || (state_q == REWIND)),
    .en      (rd_fire),
    .term    (len_q - 1'b1),
    .cnt     (rd_cnt),
    .at_term (rd_at_term)
  );

  reuse_counter #(.WIDTH(CNT_WIDTH)) u_pass_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == CLEAR),
    .en      (state_q == REWIND),
    .term    (reuse_q - 1'b1),
    .cnt     (pass_idx),
    .at_term (pass_at_term)
  );

  assign unused_cnt_bits = ^{wr_cnt, rd_cnt};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    reuse_d = reuse_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ((len_clamp != '0) && (cfg_reuse != '0)) begin
            state_d = CLEAR;
            len_d   = len_clamp;
            reuse_d = cfg_reuse;
          end else begin
            state_d = DONE;
          end
        end
      end
      CLEAR:  state_d = LOAD;
      LOAD:   if (wr_fire && wr_at_term) state_d = READ;
      READ:   if (rd_fire && rd_at_term) state_d = pass_at_term ? DONE : REWIND;
      REWIND: state_d = READ;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Clears come straight from flops so the FIFO's async-clear pins never glitch.
    wr_clr_d    = (state_d == CLEAR);
    rd_clr_d    = (state_d == CLEAR) || (state_d == REWIND);
    done_d      = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    out_valid_d = rd_fire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      reuse_q     <= '0;
      wr_clr_q    <= 1'b1;
      rd_clr_q    <= 1'b1;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      reuse_q     <= reuse_d;
      wr_clr_q    <= wr_clr_d;
      rd_clr_q    <= rd_clr_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign wr_en     = wr_fire;
  assign wr_inc    = wr_fire;
  assign rd_en     = rd_fire;
  assign rd_inc    = rd_fire;
  assign wr_clr    = wr_clr_q;
  assign rd_clr    = rd_clr_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;

`ifdef FIFO_REUSE_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == CLEAR) begin
      stall_d = '0;
    end else if ((state_q == READ) && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_fifo_reuse_ctrl.sv
// Scoreboard bench for fifo_reuse_ctrl: a behavioural FIFO supplies data, a monitor checks every out_valid/done.
module tb_fifo_reuse_ctrl;
  localparam int FS = 8;
  localparam int AW = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   cfg_len = '0;
  logic [CW-1:0] cfg_reuse = '0;
  logic          in_valid = 1'b1;
  logic          out_ready = 1'b1;
  logic          in_ready, out_valid, wr_en, wr_inc, rd_en, rd_inc, wr_clr, rd_clr, busy, done;
  logic [CW-1:0] pass_idx;
`ifdef FIFO_REUSE_PERF_EN
  logic [15:0]   stall_cycles;
`endif

  fifo_reuse_ctrl #(.FIFO_SIZE(FS), .ADD_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_reuse(cfg_reuse),
    .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
    .wr_en(wr_en), .wr_inc(wr_inc), .rd_en(rd_en), .rd_inc(rd_inc),
    .wr_clr(wr_clr), .rd_clr(rd_clr), .pass_idx(pass_idx), .busy(busy),
`ifdef FIFO_REUSE_PERF_EN
    .stall_cycles(stall_cycles),
`endif
    .done(done)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Behavioural single-clock FIFO with registered read, driven by the DUT pins.
  logic [7:0]    mem [FS];
  logic [AW-1:0] wp = '0;
  logic [AW-1:0] rp = '0;
  logic [7:0]    dout = '0;
  logic [7:0]    seed = '0;

  function automatic logic [7:0] din_of(input int idx);
    return 8'((idx + 1) * 17) ^ seed;
  endfunction

  always @(posedge clk) begin
    if (wr_en) mem[wp] <= din_of(int'(wp));
    if (wr_clr) wp <= '0;
    else if (wr_inc) wp <= wp + 1'b1;
    if (rd_en) dout <= mem[rp];
    if (rd_clr) rp <= '0;
    else if (rd_inc) rp <= rp + 1'b1;
  end

  typedef struct {
    int data;
    int cyc;
  } exp_t;
  exp_t exp_q[$];
  int   done_q[$];
  int   exp_stalls = -1;
  int   wr_seen = 0, rd_seen = 0, clr_seen = 0;
  bit   toggle_mode = 1'b0;

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = toggle_mode ? cyc[0] : 1'b1;
  end

  // Monitor: sample away from the active edge and pop the scoreboard.
  initial forever begin
    @(negedge clk);
    if (wr_en) wr_seen++;
    if (rd_en) rd_seen++;
    if (wr_clr || rd_clr) clr_seen++;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", int'(dout), e.data);
        chk("out_cycle", cyc, e.cyc);
        $display("out  cycle %0d data 0x%02h", cyc, dout);
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        chk("done_cycle", cyc, done_q.pop_front());
        $display("done cycle %0d", cyc);
`ifdef FIFO_REUSE_PERF_EN
        if (exp_stalls >= 0) chk("stall_cycles", int'(stall_cycles), exp_stalls);
`endif
      end
    end
  end

  task automatic do_start(input int len, input int reuse, input bit want_even, output int t);
    @(posedge clk);
    #1;
    if (want_even && cyc[0]) begin
      @(posedge clk);
      #1;
    end
    cfg_len   = (AW+1)'(len);
    cfg_reuse = CW'(reuse);
    start     = 1'b1;
    t         = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic push_full(input int t, input int eff, input int reuse);
    for (int p = 0; p < reuse; p++)
      for (int i = 0; i < eff; i++)
        exp_q.push_back('{data: int'(din_of(i)), cyc: t + 3 + eff + p * (eff + 1) + i});
    done_q.push_back(t + 2 + eff + reuse * eff + (reuse - 1));
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(name, exp_q.size() + done_q.size(), 0);
    repeat (3) @(posedge clk);
    exp_q.delete();
    done_q.delete();
  endtask

  task automatic clear_seen();
    wr_seen  = 0;
    rd_seen  = 0;
    clr_seen = 0;
  endtask

  initial begin
    int t;
    int n;

    // Reset release
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_clr", int'(wr_clr), 1);
    chk("rst_rd_clr", int'(rd_clr), 1);
    chk("rst_busy", int'(busy), 0);
    #2 rst = 1'b0;
    #1;
    chk("pre_edge_wr_clr", int'(wr_clr), 1);
    chk("pre_edge_rd_clr", int'(rd_clr), 1);
    @(posedge clk);
    #1;
    chk("post_edge_wr_clr", int'(wr_clr), 0);
    chk("post_edge_rd_clr", int'(rd_clr), 0);
    chk("post_edge_busy", int'(busy), 0);
    chk("post_edge_done", int'(done), 0);
    chk("post_edge_out_valid", int'(out_valid), 0);
    chk("post_edge_pass_idx", int'(pass_idx), 0);
    chk("post_edge_in_ready", int'(in_ready), 0);

    // len 4, reuse 3, full throughput; a start during LOAD must be ignored
    seed = 8'h00;
    exp_stalls = 0;
    clear_seen();
    do_start(4, 3, 1'b0, t);
    push_full(t, 4, 3);
    @(posedge clk);
    #1;
    cfg_len = 5'd1; cfg_reuse = 8'd1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain("full_timeout", 100);
    chk("full_wr_count", wr_seen, 4);
    chk("full_rd_count", rd_seen, 12);

    // out_ready toggling: reads on odd cycles only, 10 stall cycles, done at t+30
    seed = 8'h5A;
    exp_stalls = 10;
    toggle_mode = 1'b1;
    clear_seen();
    do_start(4, 3, 1'b1, t);
    for (int k = 0; k < 12; k++)
      exp_q.push_back('{data: int'(din_of(k % 4)), cyc: t + 8 + 2 * k});
    done_q.push_back(t + 30);
    drain("toggle_timeout", 100);
    toggle_mode = 1'b0;
    chk("toggle_wr_count", wr_seen, 4);
    chk("toggle_rd_count", rd_seen, 12);

    // len 12 clamps to FIFO depth 8
    seed = 8'h33;
    exp_stalls = 0;
    clear_seen();
    do_start(12, 2, 1'b0, t);
    push_full(t, 8, 2);
    drain("clamp_timeout", 100);
    chk("clamp_wr_count", wr_seen, 8);
    chk("clamp_rd_count", rd_seen, 16);

    // Degenerate configs go straight to DONE with no FIFO activity
    exp_stalls = -1;
    clear_seen();
    do_start(4, 0, 1'b0, t);
    done_q.push_back(t + 1);
    drain("reuse0_timeout", 20);
    do_start(0, 2, 1'b0, t);
    done_q.push_back(t + 1);
    drain("len0_timeout", 20);
    chk("degenerate_wr_count", wr_seen, 0);
    chk("degenerate_rd_count", rd_seen, 0);
    chk("degenerate_clr_count", clr_seen, 0);

    // Async reset during READ of pass 1, then a clean rerun
    seed = 8'h0F;
    exp_stalls = 0;
    do_start(4, 3, 1'b0, t);
    push_full(t, 4, 3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(pass_idx == 8'd1 && rd_en) && n < 100);
    chk("midread_reached", int'(pass_idx == 8'd1 && rd_en), 1);
    #2 rst = 1'b1;
    exp_q.delete();
    done_q.delete();
    #1;
    chk("abort_wr_clr", int'(wr_clr), 1);
    chk("abort_rd_clr", int'(rd_clr), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_rd_en", int'(rd_en), 0);
    chk("abort_pass_idx", int'(pass_idx), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rerun_clr_released", int'(wr_clr | rd_clr), 0);
    clear_seen();
    do_start(4, 3, 1'b0, t);
    push_full(t, 4, 3);
    drain("rerun_timeout", 100);
    chk("rerun_wr_count", wr_seen, 4);
    chk("rerun_rd_count", rd_seen, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, expected completion before 100000 time units");
    $fatal(1, "global timeout");
  end
endmodule
